// File: rtl/echo_sequencer_if.sv
// rtl/echo_sequencer_if.sv - ADC, delay RAM and DAC signal bundle for the echo sequencer
// master = sequencer side, slave = ADC/RAM/DAC side.
interface echo_sequencer_if #(
  parameter int ADDR_W = 13,
  parameter int DW     = 10
);
  logic              adc_start;
  logic [DW-1:0]     adc_data;
  logic              adc_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic              ram_we;
  logic [DW-1:0]     ram_rdata;
  logic [DW-1:0]     dac_data;
  logic              dac_start;

  modport master (
    output adc_start, ram_addr, ram_wdata, ram_we, dac_data, dac_start,
    input  adc_data, adc_valid, ram_rdata
  );

  modport slave (
    input  adc_start, ram_addr, ram_wdata, ram_we, dac_data, dac_start,
    output adc_data, adc_valid, ram_rdata
  );
endinterface

// File: rtl/echo_sequencer.sv
// rtl/echo_sequencer.sv - per-sample ADC capture, circular delay buffer and echo mix
// One sample per tick: convert, read delayed sample, store new sample, mix, start DAC.
module echo_sequencer #(
  parameter int ADDR_W  = 13,
  parameter int DW      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [ADDR_W-1:0] delay_len,
  echo_sequencer_if.master  bus,
  output logic              busy,
  output logic              overrun,
  output logic              adc_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] MID   = DW'(1 << (DW - 1));
  localparam logic [DW:0]   MID_W = (DW + 1)'(1 << (DW - 1));
  localparam logic signed [DW+1:0] Y_MAX = (DW + 2)'((1 << (DW - 1)) - 1);
  localparam logic signed [DW+1:0] Y_MIN = (DW + 2)'(-(1 << (DW - 1)));

  typedef enum logic [2:0] {
    IDLE, ADC_WAIT, RD_ADDR, RD_DATA, WRITE, MIX, DAC_GO
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [DW-1:0]     wdata_q;
  logic              we_q;
  logic              adc_start_q;
  logic              dac_start_q;
  logic [DW-1:0]     dac_data_q;
  logic [DW-1:0]     x_q;
  logic [DW-1:0]     d_q;
  logic              zero_q;
  logic              valid_q;
  logic [CW-1:0]     cnt;

  logic signed [DW:0]   s;
  logic signed [DW:0]   e;
  logic signed [DW+1:0] y;
  logic [DW-1:0]        r;

  assign rd_addr = wr_ptr - delay_len;

  // The read address goes straight out in RD_ADDR so delay_len is taken in that cycle.
  assign bus.ram_addr  = (state == RD_ADDR) ? rd_addr : addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_we    = we_q;
  assign bus.adc_start = adc_start_q;
  assign bus.dac_start = dac_start_q;
  assign bus.dac_data  = dac_data_q;

  assign busy    = (state != IDLE);
  assign overrun = tick & busy;

  always_comb begin
    s = $signed({1'b0, x_q} - MID_W);
    e = $signed({1'b0, d_q} - MID_W);
    y = $signed({s[DW], s}) + $signed({e[DW], e[DW], e[DW:1]});
    if (y > Y_MAX) begin
      r = '1;
    end else if (y < Y_MIN) begin
      r = '0;
    end else begin
      r = {~y[DW-1], y[DW-2:0]};
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      adc_start_q <= 1'b0;
      dac_start_q <= 1'b0;
      dac_data_q  <= MID;
      adc_timeout <= 1'b0;
      x_q         <= MID;
      d_q         <= MID;
      zero_q      <= 1'b0;
      valid_q     <= 1'b1;
      cnt         <= '0;
    end else begin
      valid_q     <= bus.adc_valid;
      adc_start_q <= 1'b0;
      dac_start_q <= 1'b0;
      adc_timeout <= 1'b0;
      we_q        <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state       <= ADC_WAIT;
            adc_start_q <= 1'b1;
            cnt         <= '0;
          end
        end
        ADC_WAIT: begin
          if (bus.adc_valid && !valid_q) begin
            x_q   <= bus.adc_data;
            state <= RD_ADDR;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            x_q         <= MID;
            adc_timeout <= 1'b1;
            state       <= RD_ADDR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_ADDR: begin
          addr_q <= rd_addr;
          zero_q <= (delay_len == '0);
          state  <= RD_DATA;
        end
        RD_DATA: begin
          d_q     <= zero_q ? MID : bus.ram_rdata;
          addr_q  <= wr_ptr;
          wdata_q <= x_q;
          we_q    <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          state <= MIX;
        end
        MIX: begin
          dac_data_q  <= r;
          dac_start_q <= 1'b1;
          state       <= DAC_GO;
        end
        DAC_GO: begin
          wr_ptr <= wr_ptr + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_sequencer.sv
// tb/tb_echo_sequencer.sv - randomized self-checking bench for echo_sequencer
// Uses a 16-entry buffer so wrap-around is reachable; RAM is modelled behaviourally.
module tb_echo_sequencer;
  localparam int AW = 4;
  localparam int DW = 10;

  logic          sysclk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic [AW-1:0] delay_len;
  logic          busy;
  logic          overrun;
  logic          adc_timeout;

  echo_sequencer_if #(.ADDR_W(AW), .DW(DW)) bus ();

  echo_sequencer #(.ADDR_W(AW), .DW(DW), .TIMEOUT(255)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .tick        (tick),
    .delay_len   (delay_len),
    .bus         (bus.master),
    .busy        (busy),
    .overrun     (overrun),
    .adc_timeout (adc_timeout)
  );

  always #10 sysclk = ~sysclk;

  logic [DW-1:0] mem [16];
  logic          mem_clear;
  always @(posedge sysclk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 10'd512;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_adc_start = 0;
  int n_dac_start = 0;
  always @(negedge sysclk) begin
    if (bus.adc_start) n_adc_start++;
    if (bus.dac_start) n_dac_start++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the buffer as the spec describes it, an array indexed by sample slot.
  int mref [16];
  int mptr;

  task automatic model_step(input int x, input int dl, output int exp_rd, output int exp_wr,
                            output int exp_dac);
    int d, ev, half, y;
    exp_rd = (mptr - dl + 16) % 16;
    exp_wr = mptr;
    d = (dl == 0) ? 512 : mref[exp_rd];
    ev = d - 512;
    half = (ev >= 0) ? ev / 2 : -((1 - ev) / 2);
    y = (x - 512) + half;
    if (y > 511) y = 511;
    if (y < -512) y = -512;
    exp_dac = y + 512;
    mref[mptr] = x;
    mptr = (mptr + 1) % 16;
  endtask

  task automatic apply_reset();
    @(negedge sysclk);
    rst_n = 1'b0;
    tick = 1'b0;
    bus.adc_valid = 1'b0;
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    mptr = 0;
    @(negedge sysclk);
  endtask

  // Runs one sample; lat > 0 raises adc_valid lat cycles after adc_start, lat <= 0 waits for timeout.
  task automatic run_sample(input int x, input int lat, input int dl, output int rd_a,
                            output int wr_a, output int wr_d, output int dac, output logic ok,
                            output int tcnt);
    int k;
    ok = 1'b1;
    tcnt = 0;
    @(negedge sysclk);
    tick = 1'b1;
    delay_len = AW'(dl);
    bus.adc_data = DW'(x);
    #1 if (overrun) ok = 1'b0;
    @(negedge sysclk);
    tick = 1'b0;
    if (!bus.adc_start || !busy) ok = 1'b0;
    if (lat > 0) begin
      repeat (lat) @(negedge sysclk);
      bus.adc_valid = 1'b1;
      @(negedge sysclk);
    end else begin
      k = 0;
      while (!adc_timeout && k < 400) begin
        @(negedge sysclk);
        k++;
      end
      tcnt = k;
    end
    rd_a = int'(bus.ram_addr);
    if (bus.ram_we) ok = 1'b0;
    repeat (2) @(negedge sysclk);
    wr_a = int'(bus.ram_addr);
    wr_d = int'(bus.ram_wdata);
    if (!bus.ram_we) ok = 1'b0;
    @(negedge sysclk);
    if (bus.ram_we || bus.dac_start) ok = 1'b0;
    @(negedge sysclk);
    dac = int'(bus.dac_data);
    if (!bus.dac_start || !busy) ok = 1'b0;
    @(negedge sysclk);
    if (bus.dac_start || busy) ok = 1'b0;
    bus.adc_valid = 1'b0;
  endtask

  task automatic test_reset();
    mem_clear = 1'b1;
    rst_n = 1'b0;
    tick = 1'b0;
    delay_len = '0;
    bus.adc_data = '0;
    bus.adc_valid = 1'b0;
    repeat (3) @(negedge sysclk);
    mem_clear = 1'b0;
    n_checks++;
    if ({bus.adc_start, bus.ram_we, bus.dac_start, busy, overrun, adc_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus.adc_start, bus.ram_we, bus.dac_start, busy, overrun, adc_timeout});
    end
    n_checks++;
    if (bus.dac_data !== 10'd512 || bus.ram_addr !== 4'd0 || bus.ram_wdata !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_data: dac=%0d addr=%0d wdata=%0d want 512 0 0",
               bus.dac_data, bus.ram_addr, bus.ram_wdata);
    end
    rst_n = 1'b1;
    mptr = 0;
    repeat (2) @(negedge sysclk);
    n_checks++;
    if (busy !== 1'b0 || bus.adc_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b adc_start=%b want 0 0", busy, bus.adc_start);
    end
  endtask

  task automatic test_delay();
    int seq [7] = '{512, 512, 512, 900, 512, 512, 512};
    int rd_a, wr_a, wr_d, dac, tc, er, ew, ed;
    logic ok;
    for (int i = 0; i < 7; i++) begin
      model_step(seq[i], 3, er, ew, ed);
      run_sample(seq[i], $urandom_range(1, 40), 3, rd_a, wr_a, wr_d, dac, ok, tc);
      n_checks++;
      if (dac !== ed || rd_a !== er || ok !== 1'b1) begin
        n_fail++;
        $display("FAIL delay[%0d]: dac=%0d rd=%0d ok=%b want %0d %0d 1", i, dac, rd_a, ok, ed, er);
      end
      if (i == 6) begin
        n_checks++;
        if (dac !== 706) begin
          n_fail++;
          $display("FAIL delay_echo: dac=%0d want 706", dac);
        end
      end
    end
  endtask

  task automatic test_basic();
    int rd_a, wr_a, wr_d, dac, tc, er, ew, ed;
    logic ok;
    apply_reset();
    model_step(700, 0, er, ew, ed);
    run_sample(700, 20, 0, rd_a, wr_a, wr_d, dac, ok, tc);
    n_checks++;
    if (wr_a !== 0 || wr_d !== 700 || ok !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_write: addr=%0d wdata=%0d ok=%b want 0 700 1", wr_a, wr_d, ok);
    end
    n_checks++;
    if (dac !== 700 || dac !== ed) begin
      n_fail++;
      $display("FAIL basic_dac: dac=%0d want 700", dac);
    end
  endtask

  task automatic test_saturation();
    int xs [4] = '{1023, 1023, 0, 0};
    int rd_a, wr_a, wr_d, dac, tc, er, ew, ed;
    logic ok;
    for (int i = 0; i < 4; i++) begin
      model_step(xs[i], 1, er, ew, ed);
      run_sample(xs[i], $urandom_range(1, 30), 1, rd_a, wr_a, wr_d, dac, ok, tc);
      n_checks++;
      if (dac !== ed || ok !== 1'b1) begin
        n_fail++;
        $display("FAIL sat[%0d]: dac=%0d ok=%b want %0d 1", i, dac, ok, ed);
      end
      if (i == 1 || i == 3) begin
        n_checks++;
        if (dac !== ((i == 1) ? 1023 : 0)) begin
          n_fail++;
          $display("FAIL sat_clamp[%0d]: dac=%0d want %0d", i, dac, (i == 1) ? 1023 : 0);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int rd_a, wr_a, wr_d, dac, tc, er, ew, ed, x, dl;
    logic ok;
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      x = $urandom_range(0, 1023);
      dl = (i == 16) ? 15 : $urandom_range(1, 15);
      model_step(x, dl, er, ew, ed);
      run_sample(x, $urandom_range(1, 20), dl, rd_a, wr_a, wr_d, dac, ok, tc);
      n_checks++;
      if (wr_a !== (i % 16) || wr_d !== x || rd_a !== er || dac !== ed || ok !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap[%0d]: wr=%0d/%0d rd=%0d dac=%0d ok=%b want %0d/%0d %0d %0d 1",
                 i, wr_a, wr_d, rd_a, dac, ok, i % 16, x, er, ed);
      end
    end
    n_checks++;
    if (rd_a !== 1) begin
      n_fail++;
      $display("FAIL wrap_read: rd=%0d want 1", rd_a);
    end
  endtask

  task automatic test_random();
    int rd_a, wr_a, wr_d, dac, tc, er, ew, ed, x, dl;
    logic ok;
    for (int i = 0; i < 20; i++) begin
      x = $urandom_range(0, 1023);
      dl = $urandom_range(0, 15);
      model_step(x, dl, er, ew, ed);
      run_sample(x, $urandom_range(1, 60), dl, rd_a, wr_a, wr_d, dac, ok, tc);
      n_checks++;
      if (wr_a !== ew || wr_d !== x || rd_a !== er || dac !== ed || ok !== 1'b1) begin
        n_fail++;
        $display("FAIL random[%0d]: wr=%0d rd=%0d dac=%0d ok=%b want %0d %0d %0d 1",
                 i, wr_a, rd_a, dac, ok, ew, er, ed);
      end
    end
  endtask

  task automatic test_timeout();
    int rd_a, wr_a, wr_d, dac, tc, er, ew, ed;
    logic ok;
    bus.adc_valid = 1'b1;
    repeat (3) @(negedge sysclk);
    model_step(512, 0, er, ew, ed);
    run_sample(333, 0, 0, rd_a, wr_a, wr_d, dac, ok, tc);
    n_checks++;
    if (tc !== 255) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d want 255", tc);
    end
    n_checks++;
    if (dac !== 512 || wr_d !== 512 || ok !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_data: dac=%0d wdata=%0d ok=%b want 512 512 1", dac, wr_d, ok);
    end
  endtask

  task automatic test_back_to_back();
    int a0, d0, k, er, ew, ed, x, dac;
    logic ov;
    a0 = n_adc_start;
    d0 = n_dac_start;
    x = $urandom_range(0, 1023);
    model_step(x, 0, er, ew, ed);
    @(negedge sysclk);
    tick = 1'b1;
    delay_len = '0;
    bus.adc_data = DW'(x);
    @(negedge sysclk);
    tick = 1'b0;
    repeat (2) @(negedge sysclk);
    tick = 1'b1;
    #1 ov = overrun;
    @(negedge sysclk);
    tick = 1'b0;
    repeat (4) @(negedge sysclk);
    bus.adc_valid = 1'b1;
    k = 0;
    while (!bus.dac_start && k < 30) begin
      @(negedge sysclk);
      k++;
    end
    dac = int'(bus.dac_data);
    repeat (8) @(negedge sysclk);
    bus.adc_valid = 1'b0;
    @(negedge sysclk);
    n_checks++;
    if (ov !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_pulse: got %b want 1", ov);
    end
    n_checks++;
    if (n_adc_start - a0 !== 1 || n_dac_start - d0 !== 1) begin
      n_fail++;
      $display("FAIL overrun_count: adc_start=%0d dac_start=%0d want 1 1",
               n_adc_start - a0, n_dac_start - d0);
    end
    n_checks++;
    if (dac !== ed) begin
      n_fail++;
      $display("FAIL overrun_dac: dac=%0d want %0d", dac, ed);
    end
  endtask

  task automatic test_reset_mid();
    int d0, rd_a, wr_a, wr_d, dac, tc, er, ew, ed, x;
    logic ok;
    @(negedge sysclk);
    tick = 1'b1;
    delay_len = '0;
    bus.adc_data = 10'd77;
    @(negedge sysclk);
    tick = 1'b0;
    repeat (3) @(negedge sysclk);
    bus.adc_valid = 1'b1;
    repeat (3) @(negedge sysclk);
    n_checks++;
    if (bus.ram_we !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_write_phase: ram_we=%b want 1", bus.ram_we);
    end
    d0 = n_dac_start;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ram_we !== 1'b0 || busy !== 1'b0 || bus.dac_data !== 10'd512) begin
      n_fail++;
      $display("FAIL mid_reset: we=%b busy=%b dac=%0d want 0 0 512", bus.ram_we, busy, bus.dac_data);
    end
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    bus.adc_valid = 1'b0;
    mptr = 0;
    repeat (10) @(negedge sysclk);
    n_checks++;
    if (n_dac_start !== d0) begin
      n_fail++;
      $display("FAIL mid_no_dac: dac_start count %0d want %0d", n_dac_start, d0);
    end
    x = $urandom_range(0, 1023);
    model_step(x, 0, er, ew, ed);
    run_sample(x, 5, 0, rd_a, wr_a, wr_d, dac, ok, tc);
    n_checks++;
    if (wr_a !== 0 || dac !== ed || ok !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_ptr: wr=%0d dac=%0d ok=%b want 0 %0d 1", wr_a, dac, ok, ed);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mref[i] = 512;
    mptr = 0;
    test_reset();
    test_delay();
    test_basic();
    test_saturation();
    test_wrap();
    test_random();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
